// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, default widths and issue-slot state encoding.
package alu_pkg;

    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned DEF_DW     = 32;
    localparam int unsigned OP_W       = 4;

    localparam logic [OP_W-1:0] OP_AND  = 4'd0;
    localparam logic [OP_W-1:0] OP_OR   = 4'd1;
    localparam logic [OP_W-1:0] OP_LW   = 4'd2;
    localparam logic [OP_W-1:0] OP_SW   = 4'd3;
    localparam logic [OP_W-1:0] OP_ADDU = 4'd4;
    localparam logic [OP_W-1:0] OP_SUBU = 4'd5;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd6;
    localparam logic [OP_W-1:0] OP_BLEZ = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd8;
    localparam logic [OP_W-1:0] OP_SRAV = 4'd9;
    localparam logic [OP_W-1:0] OP_LUI  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd11;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd12;
    localparam logic [OP_W-1:0] OP_SMUL = 4'd13;
    localparam logic [OP_W-1:0] OP_BGTZ = 4'd14;

    // FULL_HAZ is not stored: it is FULL qualified by the live hazard term.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_e;

    // Immediate-shift ops read shamt from src1[10:6], so src1 carries the immediate.
    function automatic logic is_shift_imm(input logic [OP_W-1:0] op);
        return (op == OP_SRA) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: EX/MEM result beats MEM/WB result beats the supplied value; r0 never bypassed.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned DW     = DEF_DW
) (
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DW-1:0]     i_val,
    input  logic              i_exmem_reg_write,
    input  logic              i_exmem_mem_read,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DW-1:0]     i_exmem_result,
    input  logic              i_memwb_reg_write,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DW-1:0]     i_memwb_result,
    output logic [DW-1:0]     o_val
);

    logic w_nonzero;
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_nonzero = (i_addr != '0);
    // A load in EX/MEM has no data yet; that case is handled as a hazard instead.
    assign w_ex_hit  = i_exmem_reg_write && !i_exmem_mem_read && (i_exmem_rd == i_addr) && w_nonzero;
    assign w_wb_hit  = i_memwb_reg_write && (i_memwb_rd == i_addr) && w_nonzero;

    always_comb begin
        o_val = i_val;
        if (w_ex_hit) begin
            o_val = i_exmem_result;
        end else if (w_wb_hit) begin
            o_val = i_memwb_result;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue slot: holds one decoded instruction, keeps its operands bypass-fresh,
// inserts load-use bubbles and hands off to the ALU with valid/ready on both sides.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned DW     = DEF_DW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rs_used_i,
    input  logic              rt_used_i,
    input  logic [DW-1:0]     rs_data_i,
    input  logic [DW-1:0]     rt_data_i,
    input  logic [DW-1:0]     imm_i,
    input  logic              src2_imm_i,
    input  logic [3:0]        alu_op_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              flush_i,
    input  logic              exmem_reg_write_i,
    input  logic              exmem_mem_read_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DW-1:0]     exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DW-1:0]     memwb_result_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [DW-1:0]     src1_o,
    output logic [DW-1:0]     src2_o,
    output logic [3:0]        ctrl_o,
    output logic [DW-1:0]     store_data_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              hazard_o
);

    issue_state_e      r_state;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_rs_used;
    logic              r_rt_used;
    logic [DW-1:0]     r_rs_data;
    logic [DW-1:0]     r_rt_data;
    logic [DW-1:0]     r_imm;
    logic              r_src2_imm;
    logic [3:0]        r_alu_op;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;

    logic              w_full;
    logic              w_load_in_ex;
    logic              w_hazard;
    logic              w_valid;
    logic              w_fire;
    logic              w_in_ready;
    logic              w_capture;
    logic [DW-1:0]     w_rs_cap;
    logic [DW-1:0]     w_rt_cap;
    logic [DW-1:0]     w_rs_fwd;
    logic [DW-1:0]     w_rt_fwd;

    fwd_mux #(.REG_AW(REG_AW), .DW(DW)) u_fwd_rs_cap (
        .i_addr           (rs_addr_i),
        .i_val            (rs_data_i),
        .i_exmem_reg_write(exmem_reg_write_i),
        .i_exmem_mem_read (exmem_mem_read_i),
        .i_exmem_rd       (exmem_rd_i),
        .i_exmem_result   (exmem_result_i),
        .i_memwb_reg_write(memwb_reg_write_i),
        .i_memwb_rd       (memwb_rd_i),
        .i_memwb_result   (memwb_result_i),
        .o_val            (w_rs_cap)
    );

    fwd_mux #(.REG_AW(REG_AW), .DW(DW)) u_fwd_rt_cap (
        .i_addr           (rt_addr_i),
        .i_val            (rt_data_i),
        .i_exmem_reg_write(exmem_reg_write_i),
        .i_exmem_mem_read (exmem_mem_read_i),
        .i_exmem_rd       (exmem_rd_i),
        .i_exmem_result   (exmem_result_i),
        .i_memwb_reg_write(memwb_reg_write_i),
        .i_memwb_rd       (memwb_rd_i),
        .i_memwb_result   (memwb_result_i),
        .o_val            (w_rt_cap)
    );

    // Output-side bypass; also the refresh value while the entry waits.
    fwd_mux #(.REG_AW(REG_AW), .DW(DW)) u_fwd_rs_out (
        .i_addr           (r_rs_addr),
        .i_val            (r_rs_data),
        .i_exmem_reg_write(exmem_reg_write_i),
        .i_exmem_mem_read (exmem_mem_read_i),
        .i_exmem_rd       (exmem_rd_i),
        .i_exmem_result   (exmem_result_i),
        .i_memwb_reg_write(memwb_reg_write_i),
        .i_memwb_rd       (memwb_rd_i),
        .i_memwb_result   (memwb_result_i),
        .o_val            (w_rs_fwd)
    );

    fwd_mux #(.REG_AW(REG_AW), .DW(DW)) u_fwd_rt_out (
        .i_addr           (r_rt_addr),
        .i_val            (r_rt_data),
        .i_exmem_reg_write(exmem_reg_write_i),
        .i_exmem_mem_read (exmem_mem_read_i),
        .i_exmem_rd       (exmem_rd_i),
        .i_exmem_result   (exmem_result_i),
        .i_memwb_reg_write(memwb_reg_write_i),
        .i_memwb_rd       (memwb_rd_i),
        .i_memwb_result   (memwb_result_i),
        .o_val            (w_rt_fwd)
    );

    assign w_full       = (r_state == ST_FULL);
    assign w_load_in_ex = exmem_mem_read_i && exmem_reg_write_i && (exmem_rd_i != '0);
    assign w_hazard     = w_full && w_load_in_ex &&
                          ((r_rs_used && (exmem_rd_i == r_rs_addr)) ||
                           (r_rt_used && (exmem_rd_i == r_rt_addr)));
    assign w_valid      = w_full && !w_hazard;
    assign w_fire       = w_valid && ex_ready_i;
    assign w_in_ready   = !flush_i && (!w_full || w_fire);
    assign w_capture    = in_valid_i && w_in_ready;

    // Slot state and payload; flush beats capture/fire, reset beats everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd_addr   <= '0;
            r_rs_used   <= 1'b0;
            r_rt_used   <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_src2_imm  <= 1'b0;
            r_alu_op    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (flush_i) begin
            r_state <= ST_EMPTY;
        end else if (w_capture) begin
            r_state     <= ST_FULL;
            r_rs_addr   <= rs_addr_i;
            r_rt_addr   <= rt_addr_i;
            r_rd_addr   <= rd_addr_i;
            r_rs_used   <= rs_used_i;
            r_rt_used   <= rt_used_i;
            r_rs_data   <= w_rs_cap;
            r_rt_data   <= w_rt_cap;
            r_imm       <= imm_i;
            r_src2_imm  <= src2_imm_i;
            r_alu_op    <= alu_op_i;
            r_reg_write <= reg_write_i;
            r_mem_read  <= mem_read_i;
            r_mem_write <= mem_write_i;
        end else if (w_fire) begin
            r_state <= ST_EMPTY;
        end else if (w_full) begin
            r_rs_data <= w_rs_fwd;
            r_rt_data <= w_rt_fwd;
        end
    end

    assign in_ready_o   = w_in_ready;
    assign ex_valid_o   = w_valid;
    assign hazard_o     = w_hazard;
    assign ctrl_o       = r_alu_op;
    assign src1_o       = is_shift_imm(r_alu_op) ? r_imm : w_rs_fwd;
    assign src2_o       = r_src2_imm ? r_imm : w_rt_fwd;
    assign store_data_o = w_rt_fwd;
    assign rd_o         = r_rd_addr;
    assign reg_write_o  = r_reg_write;
    assign mem_read_o   = r_mem_read;
    assign mem_write_o  = r_mem_write;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage sitting directly upstream of the `ALU` wrapper. It holds one decoded instruction and drives the ALU's `src1_i`/`src2_i`/`ctrl_i` each cycle. Operands are forwarded from the EX/MEM and MEM/WB result buses, and a held operand is refreshed every cycle it waits. Load-use hazards become bubbles, and handoff on both sides uses a valid/ready handshake.

## Interface
- `REG_AW`, default 5: register-address width.
- `DW`, default 32: datapath width.
- `clk_i`, in, 1: clock; everything is sampled on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `in_valid_i` in 1, `in_ready_o` out 1: decode-side handshake.
- `rs_addr_i`, `rt_addr_i`, `rd_addr_i`, in, `REG_AW`: source and destination registers.
- `rs_used_i`, `rt_used_i`, in, 1: operand is actually read (gates hazard detection).
- `rs_data_i`, `rt_data_i`, in, `DW`: register-file read data.
- `imm_i`, in, `DW`: immediate, already extended by decode.
- `src2_imm_i`, in, 1: src2 = imm instead of rt.
- `alu_op_i`, in, 4: ALU op code.
- `reg_write_i`, `mem_read_i`, `mem_write_i`, in, 1: downstream control.
- `flush_i`, in, 1: branch redirect; kill the held entry and the incoming instruction.
- `exmem_reg_write_i`, `exmem_mem_read_i` in 1; `exmem_rd_i` in `REG_AW`; `exmem_result_i` in `DW`.
- `memwb_reg_write_i` in 1; `memwb_rd_i` in `REG_AW`; `memwb_result_i` in `DW`.
- `ex_valid_o` out 1, `ex_ready_i` in 1: ALU-side handshake.
- `src1_o`, `src2_o`, out, `DW`: to the ALU `src1_i`/`src2_i`.
- `ctrl_o`, out, 4: to the ALU `ctrl_i`.
- `store_data_o`, out, `DW`: forwarded rt, for SW.
- `rd_o` out `REG_AW`; `reg_write_o`, `mem_read_o`, `mem_write_o` out 1.
- `hazard_o`, out, 1: load-use bubble this cycle.

## Operation
- **Storage:** one entry with `full` flag. States EMPTY, FULL, FULL_HAZ, where FULL_HAZ = FULL with `hazard_o`=1.
- **Forwarding function** fwd(addr, val), in priority order:
  - If `exmem_reg_write_i` and `exmem_rd_i`==addr and addr≠0 and not `exmem_mem_read_i`: return `exmem_result_i`.
  - Else if `memwb_reg_write_i` and `memwb_rd_i`==addr and addr≠0: return `memwb_result_i`.
  - Else: return val.
  - Register 0 is never forwarded.
- **Capture:** stored rs/rt data = fwd(addr, `rs_data_i`/`rt_data_i`).
- **Refresh:** every cycle an entry is held without firing, stored rs/rt data ← fwd(stored addr, stored data).
- **Operand outputs:** rsF = fwd(rs_q, rs_data_q) and rtF = fwd(rt_q, rt_data_q).
  - `src1_o` = imm_q when `ctrl_o` ∈ {SRA(8), SLL(12)}, because the ALU takes shamt from src1[10:6]. Otherwise `src1_o` = rsF.
  - `src2_o` = imm_q if src2_imm_q, else rtF.
  - `store_data_o` = rtF.
- **Hazard:** `hazard_o` is asserted when all of the following hold:
  - `full`, `exmem_mem_read_i` and `exmem_reg_write_i` are all 1;
  - `exmem_rd_i` ≠ 0;
  - (`rs_used_q` and `exmem_rd_i`==rs_q) or (`rt_used_q` and `exmem_rd_i`==rt_q).
- **Handshake:**
  - `ex_valid_o` = `full` & !`hazard_o`; fire = `ex_valid_o` & `ex_ready_i`.
  - `in_ready_o` = !`flush_i` & (!`full` | fire).
  - Capture occurs when `in_valid_i` & `in_ready_o`.
- **Transitions:**
  - EMPTY→FULL on capture.
  - FULL→EMPTY on fire without capture.
  - FULL→FULL on fire with capture (back-to-back issue).
  - FULL↔FULL_HAZ combinationally, following `hazard_o`.
- **Flush:** `flush_i`=1 forces `full` ← 0 next cycle and suppresses capture, in any state. It has priority over fire and capture.
- **Reset values:** `full`=0 and all stored fields 0. Hence `ex_valid_o`=0, `in_ready_o`=1, `hazard_o`=0, `ctrl_o`=0 (AND) and `src1_o`/`src2_o`/`store_data_o`=0 unless forwarding is active.
  - Reset mid-operation discards the entry with no output pulse.
  - Reset has priority over flush.

## Timing
- Latency: 1 cycle from capture to `ex_valid_o`, when there is no hazard.
- Throughput: 1 instruction/cycle with `ex_ready_i` held high.
- All outputs are combinational from registered state plus the EX/MEM and MEM/WB buses. There is no combinational path from `in_valid_i` to `ex_valid_o`.
- `in_ready_o` depends combinationally on `ex_ready_i`, `flush_i` and the hazard.
- A load-use bubble lasts exactly 1 cycle when MEM/WB advances every cycle.
- `ex_valid_o` is not retracted once asserted except by hazard onset, flush or reset.

## Structure
- Shared package `alu_pkg`:
  - ALU op localparams AND=0, OR=1, LW=2, SW=3, ADDU=4, SUBU=5, SLT=6, BLEZ=7, SRA=8, SRAV=9, LUI=10, SLTU=11, SLL=12, SMUL=13, BGTZ=14;
  - `REG_AW`/`DW` defaults.
- Sub-module `fwd_mux`: purely combinational fwd(); instantiated 4× (capture rs/rt, output rs/rt).

## Test plan
- **Reset, then back-to-back issue:** rst_i 1 cycle, then ADDU rs=1(5), rt=2(7) with `ex_ready_i`=1 → cycle+1: `ex_valid_o`=1, `src1_o`=5, `src2_o`=7, `ctrl_o`=4.
- **EX/MEM beats MEM/WB:** rs=3, exmem rd=3 result 0x11, memwb rd=3 result 0x22 → `src1_o`=0x11. With rd=0 on both buses → `src1_o` = register-file value.
- **Load-use:** held SUBU rs=4, exmem LW rd=4 → `hazard_o`=1, `ex_valid_o`=0, `in_ready_o`=0. Next cycle memwb rd=4 data 0x99 → `src1_o`=0x99, fire.
- **Stall refresh:** `ex_ready_i`=0 for 3 cycles while memwb writes rt=6 value 0xAB in cycle 1 only → on release, `src2_o`=0xAB.
- **Shift routing:** SLL with imm=0x140 and rt=0x1 → `src1_o`=0x140, `src2_o`=1. LUI with src2_imm=1, imm=0x1234 → `src2_o`=0x1234.
- **Flush:** flush_i together with a held entry and `in_valid_i`=1 → next cycle `ex_valid_o`=0 and the incoming instruction is not captured.
